// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every handshake and memory-bus signal around mem_port_arbiter.
//
//   Requester port n (n = 0 core fetch/load/store, n = 1 loader/debug):
//     mn_req    requester -> arbiter   request, held with payload until mn_gnt
//     mn_we     requester -> arbiter   1 = write, 0 = read
//     mn_lock   requester -> arbiter   ask to keep ownership next cycle
//     mn_addr   requester -> arbiter   byte address
//     mn_wdata  requester -> arbiter   write data
//     mn_wstrb  requester -> arbiter   write byte enables
//     mn_gnt    arbiter -> requester   request accepted this cycle
//     mn_rvalid arbiter -> requester   read data valid (cycle after a granted read)
//     mn_rdata  arbiter -> requester   read data (0 when not valid)
//   Memory side:
//     mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wstrb  arbiter -> memory
//     mem_rdata                                                   memory -> arbiter
//
//   Modports: slave = arbiter view, master = requesters + memory view.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-cycle-latency memory port between the core (port 0) and
//   the loader/debug master (port 1). One winner per cycle is chosen
//   combinationally and drives the memory bus directly; read data coming back
//   the following cycle is steered to whichever port issued the read.
//   Round-robin on ties; a requester may lock the port for up to MAX_LOCK
//   consecutive grants to perform an atomic sequence.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset; forces every output to 0 while high
//     bus    mem_port_arbiter_if.slave (requester handshakes + memory bus)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    arb_state_e        state_q,      state_d;
    logic              rr_last_q,    rr_last_d;
    logic [CNT_W-1:0]  lock_cnt_q,   lock_cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_owner_q,   rd_owner_d;

    logic              lock_eff0;
    logic              lock_eff1;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              win;
    logic              win_we;
    logic              win_lock;
    logic              win_lock_eff;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [STRB_W-1:0] win_wstrb;

    // A lock only holds while its owner keeps asking and the budget remains.
    assign lock_eff0 = (state_q == LOCK0) && bus.m0_req && bus.m0_lock
                       && (lock_cnt_q < MAX_LOCK_C);
    assign lock_eff1 = (state_q == LOCK1) && bus.m1_req && bus.m1_lock
                       && (lock_cnt_q < MAX_LOCK_C);

    // Grant selection. An expired or released lock falls through to plain
    // round-robin; since rr_last then names the lock holder, the other port
    // wins any tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (lock_eff0) begin
                gnt0 = 1'b1;
            end else if (lock_eff1) begin
                gnt1 = 1'b1;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt0 = rr_last_q;
                gnt1 = !rr_last_q;
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign win     = gnt1;

    // Winner payload; all zero when nobody is granted so the bus is quiet.
    always_comb begin
        win_we       = 1'b0;
        win_lock     = 1'b0;
        win_lock_eff = 1'b0;
        win_addr     = '0;
        win_wdata    = '0;
        win_wstrb    = '0;
        if (gnt0) begin
            win_we       = bus.m0_we;
            win_lock     = bus.m0_lock;
            win_lock_eff = lock_eff0;
            win_addr     = bus.m0_addr;
            win_wdata    = bus.m0_wdata;
            win_wstrb    = bus.m0_wstrb;
        end else if (gnt1) begin
            win_we       = bus.m1_we;
            win_lock     = bus.m1_lock;
            win_lock_eff = lock_eff1;
            win_addr     = bus.m1_addr;
            win_wdata    = bus.m1_wdata;
            win_wstrb    = bus.m1_wstrb;
        end
    end

    assign bus.m0_gnt       = gnt0;
    assign bus.m1_gnt       = gnt1;
    assign bus.mem_addr     = win_addr;
    assign bus.mem_wdata    = win_wdata;
    assign bus.mem_wstrb    = win_wstrb;
    assign bus.mem_w_enable = any_gnt && win_we;
    assign bus.mem_r_enable = any_gnt && !win_we;

    // Read return routing. Gating with reset drops a read whose data would
    // arrive while reset is asserted; the requester reissues it afterwards.
    assign bus.m0_rvalid = !reset && rd_pending_q && !rd_owner_q;
    assign bus.m1_rvalid = !reset && rd_pending_q &&  rd_owner_q;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;

    // Next-state for arbitration, lock and read tracking.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;
        if (any_gnt) begin
            rr_last_d    = win;
            rd_pending_d = !win_we;
            rd_owner_d   = win;
            if (win_lock) begin
                if (win_lock_eff) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    state_d    = win ? LOCK1 : LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end
            end else begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        end else begin
            // An idle cycle always breaks a lock.
            state_d    = ARB;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            rr_last_q    <= 1'b1;
            lock_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pending_q <= rd_pending_d;
        end
        rd_owner_q <= rd_owner_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of reads in flight: owning port and expected data.
    int               exp_port_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    // Bench copies of the payload each port presents.
    logic              p_we   [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_wdata[2];
    logic [STRB_W-1:0] p_wstrb[2];

    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return 32'hDEADBEEF ^ (a - 32'h10);
    endfunction

    // Memory model: one-cycle read latency.
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_r_enable) bus.mem_rdata <= mem_f(bus.mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [STRB_W-1:0] wstrb);
        p_we[p]    = we;
        p_addr[p]  = addr;
        p_wdata[p] = wdata;
        p_wstrb[p] = wstrb;
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
            bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
            bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_rsp();
        int p;
        logic [DATA_W-1:0] d;
        if (exp_port_q.size() > 0) begin
            p = exp_port_q.pop_front();
            d = exp_data_q.pop_front();
            chk("m0_rvalid", bus.m0_rvalid, p == 0);
            chk("m1_rvalid", bus.m1_rvalid, p == 1);
            chk("m0_rdata", bus.m0_rdata, (p == 0) ? d : '0);
            chk("m1_rdata", bus.m1_rdata, (p == 1) ? d : '0);
        end else begin
            chk("m0_rvalid_idle", bus.m0_rvalid, 1'b0);
            chk("m1_rvalid_idle", bus.m1_rvalid, 1'b0);
            chk("m0_rdata_idle", bus.m0_rdata, '0);
            chk("m1_rdata_idle", bus.m1_rdata, '0);
        end
    endtask

    // One normal cycle; exp_g = expected winner (0/1) or -1 for none.
    task automatic tick(input int exp_g);
        reset = 1'b0;
        @(negedge clk);
        check_rsp();
        chk("m0_gnt", bus.m0_gnt, exp_g == 0);
        chk("m1_gnt", bus.m1_gnt, exp_g == 1);
        if (exp_g < 0) begin
            chk("mem_r_enable_idle", bus.mem_r_enable, 1'b0);
            chk("mem_w_enable_idle", bus.mem_w_enable, 1'b0);
            chk("mem_addr_idle", bus.mem_addr, '0);
            chk("mem_wdata_idle", bus.mem_wdata, '0);
            chk("mem_wstrb_idle", bus.mem_wstrb, '0);
        end else begin
            chk("mem_addr", bus.mem_addr, p_addr[exp_g]);
            chk("mem_wdata", bus.mem_wdata, p_wdata[exp_g]);
            chk("mem_wstrb", bus.mem_wstrb, p_wstrb[exp_g]);
            chk("mem_w_enable", bus.mem_w_enable, p_we[exp_g]);
            chk("mem_r_enable", bus.mem_r_enable, !p_we[exp_g]);
            if (!p_we[exp_g]) begin
                exp_port_q.push_back(exp_g);
                exp_data_q.push_back(mem_f(p_addr[exp_g]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle with reset asserted: every output must be zero and any read
    // in flight is lost.
    task automatic tick_rst();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_m0_gnt", bus.m0_gnt, 1'b0);
        chk("rst_m1_gnt", bus.m1_gnt, 1'b0);
        chk("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
        chk("rst_mem_r_enable", bus.mem_r_enable, 1'b0);
        chk("rst_mem_w_enable", bus.mem_w_enable, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_mem_wstrb", bus.mem_wstrb, '0);
        exp_port_q.delete();
        exp_data_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int n1;
        int lock_seq[6];
        int rel_seq[3];
        int drop_seq[5];
        n0 = 0;
        n1 = 0;

        // Reset with both ports requesting: outputs must stay zero.
        drive(0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h1, 4'hF);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h2, 4'hF);
        tick_rst();
        tick_rst();
        idle_all();

        // Single read from port 0.
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0, '0);
        tick(0);
        idle_all();
        tick(-1);

        // Continuous reads from both ports after reset: 0,1,0,1,...
        tick_rst();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * n0), 32'hA0 + 32'(i), 4'h0);
            drive(1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * n1), 32'hB0 + 32'(i), 4'h0);
            tick(i % 2);
            if (i % 2 == 0) n0++;
            else n1++;
        end
        idle_all();
        tick(-1);

        // Port 1 locks with port 0 contending (rr_last is 1 here).
        lock_seq = '{0, 1, 1, 1, 1, 0};
        drive(0, 1'b1, 1'b0, 1'b0, 32'h300, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h400, '0, '0);
        for (int i = 0; i < 6; i++) tick(lock_seq[i]);
        rel_seq = '{1, 0, 1};
        drive(1, 1'b1, 1'b0, 1'b0, 32'h404, '0, '0);
        for (int i = 0; i < 3; i++) tick(rel_seq[i]);
        idle_all();
        tick(-1);

        // Write from port 0: no rvalid follows.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, 4'b0011);
        tick(0);
        idle_all();
        tick(-1);

        // Read granted, then reset the next cycle: rvalid suppressed,
        // first tie afterwards goes to port 0.
        drive(0, 1'b1, 1'b0, 1'b0, 32'h44, '0, '0);
        tick(0);
        idle_all();
        tick_rst();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h48, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h4C, '0, '0);
        tick(0);
        tick(1);
        idle_all();
        tick(-1);

        // Port 0 locks, then drops req mid-lock while port 1 waits.
        drive(0, 1'b1, 1'b0, 1'b1, 32'h50, '0, '0);
        tick(0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h60, '0, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h50, '0, '0);
        tick(1);
        // Lock budget restarts from ARB: four port-0 grants, then port 1.
        drop_seq = '{0, 0, 0, 0, 1};
        drive(0, 1'b1, 1'b0, 1'b1, 32'h54, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h64, '0, '0);
        for (int i = 0; i < 5; i++) tick(drop_seq[i]);
        idle_all();
        tick(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
